// File: rtl/sipo_pkg.sv
// Shared constants, counter-width helper and collector state type for the deserializer.
// No logic. No backpressure.
package sipo_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam bit MSB_FIRST_DEF = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } col_state_t;

  // Bits needed to count 0..v-1; legal widths start at 2, so the result is never 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_collect.sv
// Shift register and bit counter with sof realignment; word/word_done are combinational from this edge's bit.
// Latency: word_done asserts in the cycle of the last bit. No backpressure: it always accepts bits.
module sipo_collect
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] sreg, sreg_nxt, base;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_base;
  col_state_t       state;

  assign state = (cnt == '0) ? IDLE : ASSEMBLE;
  assign busy  = (state == ASSEMBLE);
  assign word  = sreg_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    base      = sreg;
    cnt_base  = cnt;
    word_done = 1'b0;
    if (clr) begin
      sreg_nxt = '0;
      cnt_nxt  = '0;
    end else if (sin_valid) begin
      // A new word (or a realignment) starts from an empty register so stale bits never leak in.
      if (sof || state == IDLE) begin
        base     = '0;
        cnt_base = '0;
      end
      if (MSB_FIRST) sreg_nxt = {base[WIDTH-2:0], sin};
      else           sreg_nxt = {sin, base[WIDTH-1:1]};
      if (cnt_base == CW'(WIDTH - 1)) begin
        word_done = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_base + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a valid/ready output holding register; dout updates on the last-bit edge.
// Backpressure: a word completing while dout is held unaccepted is dropped and sets sticky overrun.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  logic [WIDTH-1:0] word;
  logic             word_done;

  sipo_collect #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_collect (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sof       (sof),
    .word      (word),
    .word_done (word_done),
    .busy      (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      // The held word leaving on this edge frees the register for the new one.
      if (!dout_valid || dout_ready) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one MSB-first and one LSB-first instance share stimulus,
// checked every cycle against a bit-queue model plus literal expectations.
module tb_sipo_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sof = 1'b0;
  logic         dout_ready = 1'b1;
  logic [W-1:0] dout_m, dout_l;
  logic         vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready), .busy(busy_m), .overrun(ovr_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .clr(clr), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready), .busy(busy_l), .overrun(ovr_l)
  );

  // Model: received bits kept in arrival order; a full queue becomes a word.
  bit           q[$];
  logic [W-1:0] exp_m = '0, exp_l = '0;
  logic         exp_vld = 1'b0, exp_ovr = 1'b0;
  logic [W-1:0] wm, wl;
  bit           done;

  always @(posedge clk or negedge reset) begin
    if (!reset || clr) begin
      q.delete();
      exp_m = '0; exp_l = '0; exp_vld = 1'b0; exp_ovr = 1'b0;
    end else begin
      done = 1'b0;
      if (sin_valid) begin
        if (sof) q.delete();
        q.push_back(sin);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = q[i];
            wl[i]     = q[i];
          end
          q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!exp_vld || dout_ready) begin
          exp_m = wm; exp_l = wl; exp_vld = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_vld && dout_ready) begin
        exp_vld = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model dout msb", 32'(dout_m), 32'(exp_m));
      chk("model dout lsb", 32'(dout_l), 32'(exp_l));
      chk("model valid msb", 32'(vld_m), 32'(exp_vld));
      chk("model valid lsb", 32'(vld_l), 32'(exp_vld));
      chk("model overrun", 32'({ovr_m, ovr_l}), 32'({exp_ovr, exp_ovr}));
      chk("model busy", 32'({busy_m, busy_l}), 32'({q.size() != 0, q.size() != 0}));
    end
  end

  // Drive one cycle of inputs from a negedge, return at the following negedge.
  task automatic step(input logic v, input logic s, input logic f);
    sin_valid = v; sin = s; sof = f;
    @(posedge clk);
    @(negedge clk);
    sin_valid = 1'b0; sin = 1'b0; sof = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] bits);   // bits[W-1] goes first
    for (int i = W - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run = 1'b1;
    chk("reset valid", 32'(vld_m), 0);
    chk("reset dout", 32'(dout_m), 0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Basic word, one-cycle valid with ready high
    send(4'b1011);
    chk("basic dout msb", 32'(dout_m), 32'h0b);
    chk("basic dout lsb", 32'(dout_l), 32'h0d);
    chk("basic valid", 32'(vld_m), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("basic valid one cycle", 32'(vld_m), 0);
    chk("basic dout held", 32'(dout_m), 32'h0b);

    // Gaps in sin_valid keep the partial word
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("gap busy", 32'(busy_m), 1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap dout msb", 32'(dout_m), 32'h09);
    chk("gap dout lsb", 32'(dout_l), 32'h09);
    step(1'b0, 1'b0, 1'b0);

    // sof realignment drops the partial word silently
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("sof no word", 32'(vld_m), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("sof dout msb", 32'(dout_m), 32'h06);
    chk("sof dout lsb", 32'(dout_l), 32'h06);
    chk("sof no overrun", 32'(ovr_m), 0);
    step(1'b0, 1'b0, 1'b0);

    // sof without sin_valid is ignored
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("idle sof dout", 32'(dout_m), 32'h0b);
    step(1'b0, 1'b0, 1'b0);

    // Backpressure: second word dropped, overrun sticky until clr
    dout_ready = 1'b0;
    send(4'b1010);
    chk("bp first dout msb", 32'(dout_m), 32'h0a);
    chk("bp first dout lsb", 32'(dout_l), 32'h05);
    send(4'b0101);
    chk("bp dout held", 32'(dout_m), 32'h0a);
    chk("bp valid held", 32'(vld_m), 1);
    chk("bp overrun", 32'(ovr_m), 1);
    dout_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("bp drained", 32'(vld_m), 0);
    chk("bp overrun sticky", 32'(ovr_m), 1);
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    clr = 1'b0;
    chk("clr overrun", 32'(ovr_m), 0);
    chk("clr busy", 32'(busy_m), 0);
    chk("clr dout", 32'(dout_m), 0);

    // Back-to-back: second word completes on the handshake edge
    send(4'b1100);
    chk("b2b first", 32'(dout_m), 32'h0c);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 2), 1'b0);
      chk("b2b held valid", 32'(vld_m), 1);
    end
    dout_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("b2b second", 32'(dout_m), 32'h03);
    chk("b2b valid kept", 32'(vld_m), 1);
    chk("b2b no overrun", 32'(ovr_m), 0);

    // Asynchronous reset mid-word
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async rst dout", 32'(dout_m), 0);
    chk("async rst valid", 32'(vld_m), 0);
    chk("async rst busy", 32'(busy_m), 0);
    chk("async rst overrun", 32'(ovr_m), 0);
    @(negedge clk);
    reset = 1'b1;
    send(4'b0110);
    chk("post rst dout", 32'(dout_m), 32'h06);
    step(1'b0, 1'b0, 1'b0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
